envelope_line_seq: RTL

ENVELOPE_LINE_SEQ -- requirements
Module: envelope_line_seq

---
 rtl/envelope_seq_pkg.sv | 23 ++
 rtl/env_sat_trunc.sv | 24 ++
 rtl/envelope_line_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/envelope_seq_pkg.sv
// Shared types and widths for the envelope scanline sequencer.
package envelope_seq_pkg;

  localparam int DATA_W = 18;
  localparam int ENV_W  = 48;
  localparam int OUT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SKIP,
    ACQ,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_e;

  // Bits needed for a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/env_sat_trunc.sv
// Arithmetic right shift of the 48-bit envelope value, clamped to 0..65535.
module env_sat_trunc
  import envelope_seq_pkg::*;
#(
  parameter int OUT_SHIFT = 16
) (
  input  logic signed [ENV_W-1:0] din_i,
  output logic        [OUT_W-1:0] dout_o
);

  logic signed [ENV_W-1:0] shifted;

  always_comb begin
    shifted = din_i >>> OUT_SHIFT;
    if (shifted[ENV_W-1]) begin
      dout_o = '0;
    end else if (|shifted[ENV_W-2:OUT_W]) begin
      dout_o = '1;
    end else begin
      dout_o = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/envelope_line_seq.sv
// Sequences one scanline through the envelope datapath: clear, dead-zone skip,
// acquisition, pipeline flush, then decimated and saturated output capture.
module envelope_line_seq
  import envelope_seq_pkg::*;
#(
  parameter int LINE_LEN   = 2048,
  parameter int SKIP_LEN   = 64,
  parameter int CLR_CYCLES = 8,
  parameter int FLUSH_LEN  = 32,
  parameter int DECIM      = 4,
  parameter int OUT_SHIFT  = 16,
  parameter int DRAIN_MAX  = 256
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                    s_valid,
  output logic        [DATA_W-1:0] env_datai,
  output logic                    env_reset,
  input  logic                    env_valid,
  input  logic signed [ENV_W-1:0] env_dout,
  output logic        [OUT_W-1:0] m_data,
  output logic                    m_valid,
  output logic                    m_last,
  output logic                    busy,
  output logic                    line_done,
  output logic                    timeout_err
);

  localparam int CLR_W   = cnt_w(CLR_CYCLES);
  localparam int SKIP_W  = cnt_w(SKIP_LEN);
  localparam int BEAT_W  = cnt_w(LINE_LEN);
  localparam int FLUSH_W = cnt_w(FLUSH_LEN);
  localparam int DRAIN_W = cnt_w(DRAIN_MAX);
  localparam int CAP_W   = cnt_w(LINE_LEN + 1);
  localparam int DEC_W   = cnt_w(DECIM);
  localparam int LAST_K  = DECIM * ((LINE_LEN + DECIM - 1) / DECIM - 1);

  seq_state_e         state_q, state_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [OUT_W-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               last_seen_q, last_seen_d;
  logic               timeout_q, timeout_d;

  logic [OUT_W-1:0]   sat_data;
  logic               abort_hit;
  logic               cap_en;

  env_sat_trunc #(.OUT_SHIFT(OUT_SHIFT)) u_sat (
    .din_i  (env_dout),
    .dout_o (sat_data)
  );

  assign abort_hit = abort && (state_q != IDLE);
  assign cap_en    = env_valid && (cap_cnt_q < CAP_W'(LINE_LEN)) &&
                     ((state_q == ACQ) || (state_q == FLUSH) || (state_q == DRAIN));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can infer a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    last_seen_d = last_seen_q;
    timeout_d   = timeout_q;

    if (cap_en) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
      dec_cnt_d = (dec_cnt_q == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
      if (dec_cnt_q == '0) begin
        m_valid_d = 1'b1;
        m_data_d  = sat_data;
        if (cap_cnt_q == CAP_W'(LAST_K)) begin
          m_last_d    = 1'b1;
          last_seen_d = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          timeout_d = 1'b0;
        end
      end
      CLEAR: begin
        skip_cnt_d  = '0;
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        drain_cnt_d = '0;
        cap_cnt_d   = '0;
        dec_cnt_d   = '0;
        last_seen_d = 1'b0;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = (SKIP_LEN == 0) ? ACQ : SKIP;
        end
      end
      SKIP: begin
        if (s_valid) begin
          skip_cnt_d = skip_cnt_q + 1'b1;
          if (skip_cnt_q == SKIP_W'(SKIP_LEN - 1)) state_d = ACQ;
        end
      end
      ACQ: begin
        if (s_valid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_W'(LINE_LEN - 1)) begin
            state_d = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_W'(FLUSH_LEN - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (last_seen_q) begin
          state_d = DONE;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_MAX - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An aborted line produces nothing further on the output stream.
    if (abort_hit) begin
      state_d   = IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
      cap_cnt_q   <= '0;
      dec_cnt_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      last_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      last_seen_q <= last_seen_d;
      timeout_q   <= timeout_d;
    end
  end

  // Samples reach the envelope only on acquisition beats; zero otherwise.
  assign env_datai   = (!reset && !abort_hit && (state_q == ACQ) && s_valid) ?
                       s_data : '0;
  assign env_reset   = reset || (state_q == CLEAR) || abort_hit;
  assign busy        = !reset && (state_q != IDLE);
  assign line_done   = !reset && (state_q == DONE);
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign timeout_err = timeout_q;

endmodule
